// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [7:0] BEQ_CTRL = 8'b00001000;

  typedef enum logic {
    RUN,
    STALL
  } state_e;

  // Forwarding source for one compare operand; EX result is younger, so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic       ok,
    input logic [4:0] r,
    input logic       ex_alu,
    input logic [4:0] ex_rd,
    input logic       mem_alu,
    input logic [4:0] mem_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ok && ex_alu && (ex_rd == r)) begin
      sel = FWD_EX;
    end else if (ok && mem_alu && (mem_rd == r)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational hazard classification: stall cycles needed and BEQ forwarding sources.
module hazard_match
  import mips_pkg::*;
#(
  parameter logic [7:0] BEQ_CTRL = mips_pkg::BEQ_CTRL
) (
  input  logic       id_valid,
  input  logic [7:0] id_ctrl,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  input  logic       fwd_en,
  output logic       is_beq,
  output logic [1:0] need,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic rs_ok;
  logic rt_ok;
  logic ex_load_hit;
  logic mem_load_hit;
  logic ex_alu;
  logic mem_alu;

  // Operand qualification, load-hit detection and need/forwarding selection.
  always_comb begin
    is_beq       = (id_ctrl == BEQ_CTRL);
    rs_ok        = id_valid && id_uses_rs && (id_rs != 5'd0);
    rt_ok        = id_valid && id_uses_rt && (id_rt != 5'd0);
    ex_alu       = ex_regwrite && !ex_memread;
    mem_alu      = mem_regwrite && !mem_memread;
    ex_load_hit  = ex_memread && ((rs_ok && (ex_rd == id_rs)) || (rt_ok && (ex_rd == id_rt)));
    mem_load_hit = mem_memread && ((rs_ok && (mem_rd == id_rs)) || (rt_ok && (mem_rd == id_rt)));

    need = 2'd0;
    if (is_beq) begin
      if (ex_load_hit) begin
        need = 2'd2;
      end else if (mem_load_hit) begin
        need = 2'd1;
      end
    end else if (ex_load_hit) begin
      need = 2'd1;
    end

    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (fwd_en && is_beq) begin
      fwd_a = fwd_sel(rs_ok, id_rs, ex_alu, ex_rd, mem_alu, mem_rd);
      fwd_b = fwd_sel(rt_ok, id_rt, ex_alu, ex_rd, mem_alu, mem_rd);
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage hazard scheduler: stall/bubble/flush FSM, branch forwarding and perf counters.
module branch_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  BEQ_CTRL = mips_pkg::BEQ_CTRL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [7:0]       id_ctrl,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             is_beq;
  logic [1:0]       need;
  logic             fwd_en;

  assign fwd_en = !rst && (state_q == RUN);

  hazard_match #(
    .BEQ_CTRL(BEQ_CTRL)
  ) u_match (
    .id_valid    (id_valid),
    .id_ctrl     (id_ctrl),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_regwrite(mem_regwrite),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .fwd_en      (fwd_en),
    .is_beq      (is_beq),
    .need        (need),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  // Next-state and same-cycle pipeline control; stall beats a taken branch.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (rst) begin
      state_d = RUN;
      rem_d   = '0;
    end else if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            rem_d       = need - 2'd1;
            state_d     = (need > 2'd1) ? STALL : RUN;
          end else if (is_beq && branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          rem_d       = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (idex_bubble && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, remaining-stall and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Table-driven scoreboard bench for branch_hazard_ctrl.
module tb_branch_hazard_ctrl;

  localparam logic [7:0] B = 8'b00001000;
  localparam logic [7:0] A = 8'b00100000;
  localparam logic [3:0] OK = 4'b1100;
  localparam logic [3:0] ST = 4'b0010;
  localparam logic [3:0] FL = 4'b1101;
  localparam logic [3:0] HD = 4'b0000;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic       valid;
    logic [7:0] ctrl;
    logic       urs;
    logic       urt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       exw;
    logic       exm;
    logic [4:0] exd;
    logic       mw;
    logic       mm;
    logic [4:0] md;
    logic       tk;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst, hold, id_valid, id_uses_rs, id_uses_rt;
  logic [7:0] id_ctrl;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, branch_taken;
  logic pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles, flush_cycles;
  logic s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [2:0] s_stall_cycles, s_flush_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];
  vec_t sb[$];
  int exp_stall = 0;
  int exp_flush = 0;
  int exp_small = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  // Narrow-counter instance used to observe saturation.
  branch_hazard_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .branch_taken(branch_taken), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
  );

  function automatic vec_t v(
    input logic r, input logic h, input logic val, input logic [7:0] c,
    input logic urs, input logic urt, input logic [4:0] rs, input logic [4:0] rt,
    input logic exw, input logic exm, input logic [4:0] exd,
    input logic mw, input logic mm, input logic [4:0] md, input logic tk,
    input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb
  );
    vec_t t;
    t = '{rst: r, hold: h, valid: val, ctrl: c, urs: urs, urt: urt, rs: rs, rt: rt,
          exw: exw, exm: exm, exd: exd, mw: mw, mm: mm, md: md, tk: tk,
          ctl: ctl, fa: fa, fb: fb};
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; hold = t.hold; id_valid = t.valid; id_ctrl = t.ctrl;
    id_uses_rs = t.urs; id_uses_rt = t.urt; id_rs = t.rs; id_rt = t.rt;
    ex_regwrite = t.exw; ex_memread = t.exm; ex_rd = t.exd;
    mem_regwrite = t.mw; mem_memread = t.mm; mem_rd = t.md; branch_taken = t.tk;
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  initial begin
    vec_t e;
    logic [7:0] got_o;
    logic [7:0] exp_o;
    drive(v(1,0,0,A,0,0,0,0, 0,0,0, 0,0,0, 0, OK,2'b00,2'b00));

    //        rst h v ctl us ut rs rt  exw exm exd  mw mm md  tk  ctl fa    fb
    vecs.push_back(v(1,0,1,A,1,1,1,2, 0,0,0, 0,0,0, 0, OK,2'b00,2'b00)); // 0 reset
    vecs.push_back(v(0,0,1,A,1,1,1,2, 0,0,0, 0,0,0, 0, OK,2'b00,2'b00)); // 1 idle
    vecs.push_back(v(0,0,1,A,1,1,3,2, 1,1,3, 0,0,0, 0, ST,2'b00,2'b00)); // 2 load-use
    vecs.push_back(v(0,0,1,A,1,1,3,2, 1,0,3, 0,0,0, 0, OK,2'b00,2'b00)); // 3 release
    vecs.push_back(v(0,0,1,A,1,1,3,2, 1,1,3, 0,0,0, 0, ST,2'b00,2'b00)); // 4
    vecs.push_back(v(0,0,1,A,1,1,3,2, 1,1,3, 0,0,0, 0, ST,2'b00,2'b00)); // 5
    vecs.push_back(v(0,0,1,A,1,1,3,2, 1,1,3, 0,0,0, 0, ST,2'b00,2'b00)); // 6
    vecs.push_back(v(0,0,1,A,1,1,1,2, 0,0,0, 0,0,0, 0, OK,2'b00,2'b00)); // 7
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,1,5, 0,0,0, 0, ST,2'b00,2'b00)); // 8 BEQ after load
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,0,5, 0,0,0, 0, ST,2'b00,2'b00)); // 9 in STALL
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,0,5, 0,0,0, 0, OK,2'b01,2'b00)); // 10 release
    vecs.push_back(v(0,0,1,B,1,1,4,4, 1,0,4, 1,0,4, 0, OK,2'b01,2'b01)); // 11 EX priority
    vecs.push_back(v(0,0,1,B,1,1,4,7, 1,0,9, 1,0,7, 0, OK,2'b00,2'b10)); // 12 MEM on rt
    vecs.push_back(v(0,0,1,B,1,1,0,1, 1,1,0, 1,0,0, 0, OK,2'b00,2'b00)); // 13 r0
    vecs.push_back(v(0,0,1,B,1,1,1,2, 0,0,0, 0,0,0, 1, FL,2'b00,2'b00)); // 14 taken
    vecs.push_back(v(0,0,1,B,1,1,1,8, 0,0,0, 1,1,8, 1, ST,2'b00,2'b00)); // 15 stall+taken
    vecs.push_back(v(0,0,1,B,1,1,1,8, 0,0,0, 0,0,0, 1, FL,2'b00,2'b00)); // 16 resolves
    vecs.push_back(v(0,0,0,B,1,1,5,6, 1,1,5, 0,0,0, 0, OK,2'b00,2'b00)); // 17 invalid
    vecs.push_back(v(0,0,1,B,0,1,5,6, 1,1,5, 0,0,0, 0, OK,2'b00,2'b00)); // 18 rs unused
    vecs.push_back(v(0,0,1,A,1,1,7,2, 0,0,0, 1,1,7, 0, OK,2'b00,2'b00)); // 19 non-BEQ MEM load
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,1,5, 0,0,0, 0, ST,2'b00,2'b00)); // 20 enter STALL
    vecs.push_back(v(0,1,1,B,1,1,5,6, 1,0,5, 0,0,0, 1, HD,2'b00,2'b00)); // 21 hold in STALL
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,0,5, 0,0,0, 0, ST,2'b00,2'b00)); // 22 rem frozen
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,0,5, 0,0,0, 0, OK,2'b01,2'b00)); // 23
    vecs.push_back(v(0,1,1,B,1,1,4,6, 1,0,4, 0,0,0, 1, HD,2'b01,2'b00)); // 24 hold in RUN
    vecs.push_back(v(0,0,1,B,1,1,5,6, 1,1,5, 0,0,0, 0, ST,2'b00,2'b00)); // 25 enter STALL
    vecs.push_back(v(1,0,1,B,1,1,4,6, 1,0,4, 0,0,0, 1, OK,2'b00,2'b00)); // 26 rst in STALL
    vecs.push_back(v(0,0,1,B,1,1,4,6, 1,0,4, 0,0,0, 0, OK,2'b01,2'b00)); // 27 aborted
    vecs.push_back(v(0,0,1,A,1,1,1,2, 0,0,0, 0,0,0, 0, OK,2'b00,2'b00)); // 28 idle

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      #2;
      e = sb.pop_front();
      got_o = {pc_write, ifid_write, idex_bubble, ifid_flush, fwd_a, fwd_b};
      exp_o = {e.ctl, e.fa, e.fb};
      n_tests++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL vec%0d outputs {pc,ifid,bub,flush,fa,fb}: got %b expected %b", i, got_o, exp_o);
      end
      @(posedge clk);
      #1;
      if (e.rst) begin
        exp_stall = 0; exp_flush = 0; exp_small = 0;
      end else begin
        if (e.ctl[1]) begin
          exp_stall++;
          if (exp_small < 7) exp_small++;
        end
        if (e.ctl[0]) exp_flush++;
      end
      check_int($sformatf("vec%0d stall_cycles", i), int'(stall_cycles), exp_stall);
      check_int($sformatf("vec%0d flush_cycles", i), int'(flush_cycles), exp_flush);
      check_int($sformatf("vec%0d sat_stall_cycles", i), int'(s_stall_cycles), exp_small);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
